// File: rtl/dmem_pkg.sv
// Shared types for the data-memory access unit: size codes,
// FSM state encoding and the byte-enable generator.
`timescale 1ns/1ps
package dmem_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10,
      DONE = 2'b11
   } dmem_state_e;

   // off is the already-aligned byte offset inside the word
   function automatic logic [3:0] be_gen(
      input logic [1:0] size,
      input logic [1:0] off
   );
      logic [3:0] be;
      case (size)
         SIZE_BYTE: be = 4'b0001 << off;
         SIZE_HALF: be = 4'b0011 << {off[1], 1'b0};
         default:   be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/dmem_align.sv
// Lane steering: store-data replication across byte lanes and
// load-data extraction with sign/zero extension.
`timescale 1ns/1ps
module dmem_align
   import dmem_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [31:0] st_wdata,
   input  logic [1:0]  ld_size,
   input  logic        ld_unsigned,
   input  logic [1:0]  ld_off,
   input  logic [31:0] rdata,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);

   logic [31:0] shifted;

   always_comb begin
      wdata_rep = st_wdata;
      case (st_size)
         SIZE_BYTE: wdata_rep = {4{st_wdata[7:0]}};
         SIZE_HALF: wdata_rep = {2{st_wdata[15:0]}};
         default:   wdata_rep = st_wdata;
      endcase
   end

   always_comb begin
      shifted   = rdata >> {ld_off, 3'b000};
      rdata_ext = shifted;
      case (ld_size)
         SIZE_BYTE: begin
            if (ld_unsigned)
               rdata_ext = {24'h000000, shifted[7:0]};
            else
               rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
         end
         SIZE_HALF: begin
            if (ld_unsigned)
               rdata_ext = {16'h0000, shifted[15:0]};
            else
               rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
         end
         default: rdata_ext = shifted;
      endcase
   end

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store engine between MEM stage and the req/gnt/rvalid data bus.
// Optional DMEM_MISALIGN_TRAP_EN: trap misaligned half/word accesses.
`timescale 1ns/1ps
module dmem_access_unit
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_mem_read,
   input  logic              i_mem_write,
   input  logic [1:0]        i_d_size,
   input  logic              i_d_unsigned,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [31:0]       i_wdata,
   output logic              o_stall,
   output logic [31:0]       o_rdata,
   output logic              o_misaligned,
   output logic              o_dmem_req,
   output logic              o_dmem_we,
   output logic [3:0]        o_dmem_be,
   output logic [ADDR_W-1:0] o_dmem_addr,
   output logic [31:0]       o_dmem_wdata,
   input  logic              i_dmem_gnt,
   input  logic              i_dmem_rvalid,
   input  logic [31:0]       i_dmem_rdata
);

   dmem_state_e state;

   logic        r_we;
   logic [1:0]  r_size;
   logic        r_uns;
   logic [1:0]  r_off;
   logic        mis_q;

   logic        req_any;
   logic [1:0]  size_n;
   logic [1:0]  off_n;
   logic        misal;
   logic [31:0] wdata_rep;
   logic [31:0] rdata_ext;

   always_comb begin
      req_any = i_mem_read | i_mem_write;
      size_n  = (i_d_size == 2'b11) ? SIZE_WORD : i_d_size;
      off_n   = i_addr[1:0];
      misal   = 1'b0;
      case (size_n)
         SIZE_HALF: begin
            off_n = {i_addr[1], 1'b0};
`ifdef DMEM_MISALIGN_TRAP_EN
            misal = i_addr[0];
`endif
         end
         SIZE_WORD: begin
            off_n = 2'b00;
`ifdef DMEM_MISALIGN_TRAP_EN
            misal = |i_addr[1:0];
`endif
         end
         default: off_n = i_addr[1:0];
      endcase
   end

   assign o_stall      = req_any && (state != DONE);
   assign o_misaligned = mis_q;

   dmem_align u_align (
      .st_size     (size_n),
      .st_wdata    (i_wdata),
      .ld_size     (r_size),
      .ld_unsigned (r_uns),
      .ld_off      (r_off),
      .rdata       (i_dmem_rdata),
      .wdata_rep   (wdata_rep),
      .rdata_ext   (rdata_ext)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         r_we         <= 1'b0;
         r_size       <= SIZE_BYTE;
         r_uns        <= 1'b0;
         r_off        <= 2'b00;
         mis_q        <= 1'b0;
         o_rdata      <= '0;
         o_dmem_req   <= 1'b0;
         o_dmem_we    <= 1'b0;
         o_dmem_be    <= '0;
         o_dmem_addr  <= '0;
         o_dmem_wdata <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_any) begin
                  r_we    <= i_mem_write;
                  r_size  <= size_n;
                  r_uns   <= i_d_unsigned;
                  r_off   <= off_n;
                  o_rdata <= '0;
                  if (misal) begin
                     // trapped access never reaches the bus
                     mis_q <= 1'b1;
                     state <= DONE;
                  end else begin
                     o_dmem_req   <= 1'b1;
                     o_dmem_we    <= i_mem_write;
                     o_dmem_be    <= be_gen(size_n, off_n);
                     o_dmem_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
                     o_dmem_wdata <= wdata_rep;
                     state        <= REQ;
                  end
               end
            end
            REQ: begin
               if (i_dmem_gnt) begin
                  o_dmem_req <= 1'b0;
                  state      <= r_we ? DONE : WAIT;
               end
            end
            WAIT: begin
               if (i_dmem_rvalid) begin
                  o_rdata <= rdata_ext;
                  state   <= DONE;
               end
            end
            DONE: begin
               mis_q   <= 1'b0;
               o_rdata <= '0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed self-checking bench for dmem_access_unit.
// Bus responder with programmable gnt/rvalid delays.
`timescale 1ns/1ps
module tb_dmem_access_unit;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_read, mem_write, d_uns;
   logic [1:0]  d_size;
   logic [31:0] addr_i, wdata_i;
   logic        stall, mis;
   logic [31:0] rdata_o;
   logic        req, we;
   logic [3:0]  be;
   logic [31:0] baddr, bwdata;
   logic        gnt, rvalid;
   logic [31:0] brdata;

   int n_cmp = 0;
   int n_err = 0;

   int          r_done;
   logic [3:0]  r_be;
   logic [31:0] r_addr, r_wd, r_rdata;
   logic        r_we, r_mis, r_req_seen, r_unstable;

   always #5 clk = ~clk;

   dmem_access_unit #(.ADDR_W(32)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_mem_read    (mem_read),
      .i_mem_write   (mem_write),
      .i_d_size      (d_size),
      .i_d_unsigned  (d_uns),
      .i_addr        (addr_i),
      .i_wdata       (wdata_i),
      .o_stall       (stall),
      .o_rdata       (rdata_o),
      .o_misaligned  (mis),
      .o_dmem_req    (req),
      .o_dmem_we     (we),
      .o_dmem_be     (be),
      .o_dmem_addr   (baddr),
      .o_dmem_wdata  (bwdata),
      .i_dmem_gnt    (gnt),
      .i_dmem_rvalid (rvalid),
      .i_dmem_rdata  (brdata)
   );

   // Drives one access and records what the bus and pipeline saw.
   task automatic run_access(
      input logic        rd,
      input logic        wr,
      input logic [1:0]  sz,
      input logic        uns,
      input logic [31:0] addr,
      input logic [31:0] wdata,
      input logic [31:0] rdat,
      input int          gdly,
      input int          rdly
   );
      int req_cnt, wait_cnt;
      bit gdone;
      r_done = -1; r_req_seen = 1'b0; r_unstable = 1'b0;
      r_be = '0; r_addr = '0; r_wd = '0; r_we = 1'b0;
      r_rdata = 32'hxxxxxxxx; r_mis = 1'bx;
      req_cnt = 0; wait_cnt = 0; gdone = 1'b0;
      @(posedge clk); #1;
      mem_read = rd; mem_write = wr; d_size = sz; d_uns = uns;
      addr_i = addr; wdata_i = wdata;
      gnt = (gdly == 0); rvalid = 1'b0; brdata = 32'h5A5A5A5A;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (!stall) begin
            r_done = c; r_rdata = rdata_o; r_mis = mis;
            break;
         end
         if (gdone) wait_cnt++;
         if (req) begin
            if (!r_req_seen) begin
               r_req_seen = 1'b1;
               r_be = be; r_addr = baddr; r_wd = bwdata; r_we = we;
            end else if (be !== r_be || baddr !== r_addr ||
                         bwdata !== r_wd || we !== r_we) begin
               r_unstable = 1'b1;
            end
            req_cnt++;
            if (gnt) gdone = 1'b1;
         end
         @(posedge clk); #1;
         gnt    = !gdone && (req_cnt == gdly);
         rvalid = gdone && rd && !wr && (wait_cnt == rdly);
         brdata = rvalid ? rdat : 32'h5A5A5A5A;
      end
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0; gnt = 1'b0; rvalid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; d_size = SZ_W;
      d_uns = 1'b0; addr_i = '0; wdata_i = '0;
      gnt = 1'b0; rvalid = 1'b0; brdata = '0;
      #12;
      n_cmp++;
      if ({req, we, be, baddr, bwdata, rdata_o, mis} !== '0) begin
         n_err++;
         $display("FAIL reset_outs: got req=%b we=%b be=%b a=%h wd=%h rd=%h mis=%b want all 0",
                  req, we, be, baddr, bwdata, rdata_o, mis);
      end
      mem_read = 1'b1; #1;
      n_cmp++;
      if (stall !== 1'b1) begin
         n_err++; $display("FAIL reset_stall_hi: got %b want 1", stall);
      end
      mem_read = 1'b0; #1;
      n_cmp++;
      if (stall !== 1'b0) begin
         n_err++; $display("FAIL reset_stall_lo: got %b want 0", stall);
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_store_word;
      run_access(1'b0, 1'b1, SZ_W, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
      n_cmp++;
      if (r_done !== 2) begin
         n_err++; $display("FAIL sw_done: got %0d want 2", r_done);
      end
      n_cmp++;
      if ({r_req_seen, r_we, r_be} !== 6'b11_1111) begin
         n_err++; $display("FAIL sw_bus: got req=%b we=%b be=%b want 1 1 1111",
                           r_req_seen, r_we, r_be);
      end
      n_cmp++;
      if (r_addr !== 32'h100 || r_wd !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL sw_data: got a=%h wd=%h want 00000100 deadbeef",
                           r_addr, r_wd);
      end
   endtask

   task automatic test_store_byte;
      run_access(1'b0, 1'b1, SZ_B, 1'b0, 32'h103, 32'h000000A5, 32'h0, 0, 0);
      n_cmp++;
      if (r_be !== 4'b1000 || r_addr !== 32'h100) begin
         n_err++; $display("FAIL sb_be_addr: got be=%b a=%h want 1000 00000100",
                           r_be, r_addr);
      end
      n_cmp++;
      if (r_wd !== 32'hA5A5A5A5) begin
         n_err++; $display("FAIL sb_wdata: got %h want a5a5a5a5", r_wd);
      end
   endtask

   task automatic test_load_extend;
      run_access(1'b1, 1'b0, SZ_B, 1'b0, 32'h102, 32'h0, 32'h80FF1234, 0, 0);
      n_cmp++;
      if (r_done !== 3 || r_be !== 4'b0100 || r_we !== 1'b0) begin
         n_err++; $display("FAIL lb_bus: got done=%0d be=%b we=%b want 3 0100 0",
                           r_done, r_be, r_we);
      end
      n_cmp++;
      if (r_rdata !== 32'hFFFFFFFF) begin
         n_err++; $display("FAIL lb_rdata: got %h want ffffffff", r_rdata);
      end
      run_access(1'b1, 1'b0, SZ_B, 1'b1, 32'h102, 32'h0, 32'h80FF1234, 0, 0);
      n_cmp++;
      if (r_rdata !== 32'h000000FF) begin
         n_err++; $display("FAIL lbu_rdata: got %h want 000000ff", r_rdata);
      end
      run_access(1'b1, 1'b0, SZ_H, 1'b1, 32'h102, 32'h0, 32'h80FF1234, 0, 0);
      n_cmp++;
      if (r_rdata !== 32'h000080FF || r_be !== 4'b1100) begin
         n_err++; $display("FAIL lhu: got rd=%h be=%b want 000080ff 1100",
                           r_rdata, r_be);
      end
      run_access(1'b1, 1'b0, SZ_H, 1'b0, 32'h102, 32'h0, 32'h80FF1234, 0, 0);
      n_cmp++;
      if (r_rdata !== 32'hFFFF80FF) begin
         n_err++; $display("FAIL lh_rdata: got %h want ffff80ff", r_rdata);
      end
   endtask

   task automatic test_store_half;
      run_access(1'b0, 1'b1, SZ_H, 1'b0, 32'h102, 32'h1234ABCD, 32'h0, 0, 0);
      n_cmp++;
      if (r_be !== 4'b1100 || r_wd !== 32'hABCDABCD) begin
         n_err++; $display("FAIL sh_lanes: got be=%b wd=%h want 1100 abcdabcd",
                           r_be, r_wd);
      end
      n_cmp++;
      if (r_rdata !== 32'h0) begin
         n_err++; $display("FAIL sh_rdata: got %h want 00000000", r_rdata);
      end
   endtask

   task automatic test_wait_states;
      run_access(1'b1, 1'b0, SZ_W, 1'b0, 32'h200, 32'h0, 32'hCAFEF00D, 3, 2);
      n_cmp++;
      if (r_done !== 8) begin
         n_err++; $display("FAIL lw_wait_done: got %0d want 8", r_done);
      end
      n_cmp++;
      if (r_unstable !== 1'b0 || r_be !== 4'b1111 || r_addr !== 32'h200) begin
         n_err++; $display("FAIL lw_wait_bus: got unstable=%b be=%b a=%h want 0 1111 00000200",
                           r_unstable, r_be, r_addr);
      end
      n_cmp++;
      if (r_rdata !== 32'hCAFEF00D) begin
         n_err++; $display("FAIL lw_wait_rdata: got %h want cafef00d", r_rdata);
      end
   endtask

   task automatic test_size3;
      run_access(1'b1, 1'b0, 2'b11, 1'b1, 32'h204, 32'h0, 32'h89ABCDEF, 1, 0);
      n_cmp++;
      if (r_rdata !== 32'h89ABCDEF || r_be !== 4'b1111 || r_addr !== 32'h204) begin
         n_err++; $display("FAIL size3: got rd=%h be=%b a=%h want 89abcdef 1111 00000204",
                           r_rdata, r_be, r_addr);
      end
      n_cmp++;
      if (r_done !== 4) begin
         n_err++; $display("FAIL size3_done: got %0d want 4", r_done);
      end
   endtask

   task automatic test_rw_both;
      run_access(1'b1, 1'b1, SZ_W, 1'b0, 32'h104, 32'h11223344, 32'h0, 0, 0);
      n_cmp++;
      if (r_we !== 1'b1 || r_done !== 2 || r_wd !== 32'h11223344) begin
         n_err++; $display("FAIL rw_both: got we=%b done=%0d wd=%h want 1 2 11223344",
                           r_we, r_done, r_wd);
      end
   endtask

   task automatic test_misaligned;
      run_access(1'b1, 1'b0, SZ_H, 1'b0, 32'h101, 32'h0, 32'h12348001, 0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
      n_cmp++;
      if (r_done !== 1 || r_req_seen !== 1'b0 || r_mis !== 1'b1 || r_rdata !== 32'h0) begin
         n_err++; $display("FAIL mis_trap: got done=%0d req=%b mis=%b rd=%h want 1 0 1 0",
                           r_done, r_req_seen, r_mis, r_rdata);
      end
`else
      n_cmp++;
      if (r_addr !== 32'h100 || r_be !== 4'b0011 || r_mis !== 1'b0) begin
         n_err++; $display("FAIL mis_align: got a=%h be=%b mis=%b want 00000100 0011 0",
                           r_addr, r_be, r_mis);
      end
      n_cmp++;
      if (r_rdata !== 32'hFFFF8001 || r_done !== 3) begin
         n_err++; $display("FAIL mis_rdata: got rd=%h done=%0d want ffff8001 3",
                           r_rdata, r_done);
      end
`endif
   endtask

   task automatic test_reset_mid;
      bit bad;
      @(posedge clk); #1;
      mem_read = 1'b1; mem_write = 1'b0; d_size = SZ_W; d_uns = 1'b0;
      addr_i = 32'h300; gnt = 1'b1; rvalid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      gnt = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (req !== 1'b0 || stall !== 1'b1) begin
         n_err++; $display("FAIL rst_mid_wait: got req=%b stall=%b want 0 1", req, stall);
      end
      rst_n = 1'b0; mem_read = 1'b0; #1;
      n_cmp++;
      if (req !== 1'b0 || rdata_o !== 32'h0 || stall !== 1'b0) begin
         n_err++; $display("FAIL rst_mid_clear: got req=%b rd=%h stall=%b want 0 0 0",
                           req, rdata_o, stall);
      end
      @(posedge clk); #1;
      rst_n = 1'b1; rvalid = 1'b1; brdata = 32'hFFFFFFFF;
      @(posedge clk); #1;
      rvalid = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (rdata_o !== 32'h0 || req !== 1'b0) bad = 1'b1;
      end
      n_cmp++;
      if (bad !== 1'b0) begin
         n_err++; $display("FAIL rst_late_rvalid: got rd=%h req=%b want 0 0", rdata_o, req);
      end
      run_access(1'b1, 1'b0, SZ_W, 1'b0, 32'h304, 32'h0, 32'h13579BDF, 0, 0);
      n_cmp++;
      if (r_done !== 3 || r_rdata !== 32'h13579BDF) begin
         n_err++; $display("FAIL rst_recover: got done=%0d rd=%h want 3 13579bdf",
                           r_done, r_rdata);
      end
   endtask

   task automatic test_back_to_back;
      run_access(1'b0, 1'b1, SZ_B, 1'b0, 32'h400, 32'h0000005C, 32'h0, 0, 0);
      run_access(1'b1, 1'b0, SZ_B, 1'b1, 32'h401, 32'h0, 32'h0000C300, 0, 0);
      n_cmp++;
      if (r_done !== 3 || r_rdata !== 32'h000000C3 || r_be !== 4'b0010) begin
         n_err++; $display("FAIL b2b: got done=%0d rd=%h be=%b want 3 000000c3 0010",
                           r_done, r_rdata, r_be);
      end
   endtask

   initial begin
      test_reset();
      test_store_word();
      test_store_byte();
      test_load_extend();
      test_store_half();
      test_wait_states();
      test_size3();
      test_rw_both();
      test_misaligned();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
